// File: rtl/ctx_sequencer_pkg.sv
// Shared definitions for the PE configuration word: field ids, field placement
// and sequencer state. The PE-side field splitter imports the same package.
package ctx_sequencer_pkg;
  localparam int WIDTH = 120;
  localparam int CFG_W = WIDTH + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN} state_e;

  localparam logic [4:0] FLD_IN = 5'd0, FLD_OUT = 5'd1, FLD_PUT_IN = 5'd2, FLD_PUT_OUT = 5'd3;
  localparam logic [4:0] FLD_REG_1 = 5'd4, FLD_REG_2 = 5'd5, FLD_SEND = 5'd6, FLD_PE2FU_1 = 5'd7;
  localparam logic [4:0] FLD_PE2FU_2 = 5'd8, FLD_LD = 5'd9, FLD_IN_P = 5'd10, FLD_OUT_P = 5'd11;
  localparam logic [4:0] FLD_PUT_IN_P = 5'd12, FLD_PUT_OUT_P = 5'd13, FLD_PRED = 5'd14;
  localparam logic [4:0] FLD_SEND_P = 5'd15, FLD_PE2FU_P = 5'd16, FLD_PRED_CONTROL = 5'd17;
  localparam logic [4:0] FLD_OP_MODE = 5'd18, FLD_IMM = 5'd19, FLD_IMM_VAL = 5'd20;

  localparam int LSB_IN = 0,            W_IN = 9;
  localparam int LSB_OUT = 9,           W_OUT = 9;
  localparam int LSB_PUT_IN = 18,       W_PUT_IN = 6;
  localparam int LSB_PUT_OUT = 24,      W_PUT_OUT = 6;
  localparam int LSB_REG_1 = 30,        W_REG_1 = 6;
  localparam int LSB_REG_2 = 36,        W_REG_2 = 6;
  localparam int LSB_SEND = 42,         W_SEND = 6;
  localparam int LSB_PE2FU_1 = 48,      W_PE2FU_1 = 4;
  localparam int LSB_PE2FU_2 = 52,      W_PE2FU_2 = 4;
  localparam int LSB_LD = 56,           W_LD = 1;
  localparam int LSB_IN_P = 57,         W_IN_P = 9;
  localparam int LSB_OUT_P = 66,        W_OUT_P = 9;
  localparam int LSB_PUT_IN_P = 75,     W_PUT_IN_P = 6;
  localparam int LSB_PUT_OUT_P = 81,    W_PUT_OUT_P = 6;
  localparam int LSB_PRED = 87,         W_PRED = 6;
  localparam int LSB_SEND_P = 93,       W_SEND_P = 6;
  localparam int LSB_PE2FU_P = 99,      W_PE2FU_P = 4;
  localparam int LSB_PRED_CONTROL = 103, W_PRED_CONTROL = 1;
  localparam int LSB_OP_MODE = 104,     W_OP_MODE = 8;
  localparam int LSB_IMM = 112,         W_IMM = 1;
  localparam int LSB_IMM_VAL = 113,     W_IMM_VAL = 8;

  function automatic int fld_lsb(input logic [4:0] id);
    case (id)
      FLD_IN:           return LSB_IN;
      FLD_OUT:          return LSB_OUT;
      FLD_PUT_IN:       return LSB_PUT_IN;
      FLD_PUT_OUT:      return LSB_PUT_OUT;
      FLD_REG_1:        return LSB_REG_1;
      FLD_REG_2:        return LSB_REG_2;
      FLD_SEND:         return LSB_SEND;
      FLD_PE2FU_1:      return LSB_PE2FU_1;
      FLD_PE2FU_2:      return LSB_PE2FU_2;
      FLD_LD:           return LSB_LD;
      FLD_IN_P:         return LSB_IN_P;
      FLD_OUT_P:        return LSB_OUT_P;
      FLD_PUT_IN_P:     return LSB_PUT_IN_P;
      FLD_PUT_OUT_P:    return LSB_PUT_OUT_P;
      FLD_PRED:         return LSB_PRED;
      FLD_SEND_P:       return LSB_SEND_P;
      FLD_PE2FU_P:      return LSB_PE2FU_P;
      FLD_PRED_CONTROL: return LSB_PRED_CONTROL;
      FLD_OP_MODE:      return LSB_OP_MODE;
      FLD_IMM:          return LSB_IMM;
      FLD_IMM_VAL:      return LSB_IMM_VAL;
      default:          return 0;
    endcase
  endfunction

  // Width 0 for unmapped ids yields an empty mask, so the word passes through.
  function automatic int fld_wid(input logic [4:0] id);
    case (id)
      FLD_IN:           return W_IN;
      FLD_OUT:          return W_OUT;
      FLD_PUT_IN:       return W_PUT_IN;
      FLD_PUT_OUT:      return W_PUT_OUT;
      FLD_REG_1:        return W_REG_1;
      FLD_REG_2:        return W_REG_2;
      FLD_SEND:         return W_SEND;
      FLD_PE2FU_1:      return W_PE2FU_1;
      FLD_PE2FU_2:      return W_PE2FU_2;
      FLD_LD:           return W_LD;
      FLD_IN_P:         return W_IN_P;
      FLD_OUT_P:        return W_OUT_P;
      FLD_PUT_IN_P:     return W_PUT_IN_P;
      FLD_PUT_OUT_P:    return W_PUT_OUT_P;
      FLD_PRED:         return W_PRED;
      FLD_SEND_P:       return W_SEND_P;
      FLD_PE2FU_P:      return W_PE2FU_P;
      FLD_PRED_CONTROL: return W_PRED_CONTROL;
      FLD_OP_MODE:      return W_OP_MODE;
      FLD_IMM:          return W_IMM;
      FLD_IMM_VAL:      return W_IMM_VAL;
      default:          return 0;
    endcase
  endfunction
endpackage

// File: rtl/ctx_sequencer_if.sv
// Config-bus side of the context sequencer: field load handshake, control
// strobes and the replayed configuration word with status.
interface ctx_sequencer_if #(parameter int CW = 121, parameter int AW = 4) ();
  logic          fld_valid;
  logic          fld_ready;
  logic [4:0]    fld_id;
  logic [8:0]    fld_val;
  logic          commit;
  logic          start;
  logic          stop;
  logic          clear;
  logic [CW-1:0] data_out;
  logic          running;
  logic [AW-1:0] ctx_idx;
  logic [AW:0]   ctx_count;
  logic          err;

  modport slave (
    input  fld_valid, fld_id, fld_val, commit, start, stop, clear,
    output fld_ready, data_out, running, ctx_idx, ctx_count, err
  );
  modport master (
    output fld_valid, fld_id, fld_val, commit, start, stop, clear,
    input  fld_ready, data_out, running, ctx_idx, ctx_count, err
  );
endinterface

// File: rtl/ctx_sequencer_fld_pack.sv
// Combinational staging-word update: overwrite one field with an LSB-aligned
// value, flag ids outside the field map.
module fld_pack
  import ctx_sequencer_pkg::*;
#(parameter int CW = CFG_W) (
  input  logic [CW-1:0] i_word,
  input  logic [4:0]    i_id,
  input  logic [8:0]    i_val,
  output logic [CW-1:0] o_word,
  output logic          o_bad
);
  int            w_lsb;
  int            w_wid;
  logic [CW-1:0] w_low;
  logic [CW-1:0] w_val;

  assign w_lsb  = fld_lsb(i_id);
  assign w_wid  = fld_wid(i_id);
  assign w_low  = {{(CW-9){1'b0}}, 9'h1FF >> (9 - w_wid)};
  assign w_val  = {{(CW-9){1'b0}}, i_val} & w_low;
  assign o_word = (i_word & ~(w_low << w_lsb)) | (w_val << w_lsb);
  assign o_bad  = (i_id > FLD_IMM_VAL);
endmodule

// File: rtl/ctx_sequencer.sv
// Per-PE context packer/sequencer: builds config words field by field, stores
// them in a register-array context memory and replays them cyclically.
module ctx_sequencer
  import ctx_sequencer_pkg::*;
#(
  parameter int width = 120,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input logic            CLK,
  input logic            RST_N,
  ctx_sequencer_if.slave bus
);
  localparam int          CW      = width + 1;
  localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);

  state_e        r_state;
  logic [CW-1:0] r_stage;
  logic [CW-1:0] r_dout;
  logic [CW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_cnt;
  logic [AW-1:0] r_idx;
  logic          r_err;

  logic          w_acc;
  logic          w_bad;
  logic          w_full;
  logic          w_mem_we;
  logic [CW-1:0] w_packed;
  logic [CW-1:0] w_stage_nxt;
  logic [AW-1:0] w_nxt;

  fld_pack #(.CW(CW)) u_pack (
    .i_word (r_stage),
    .i_id   (bus.fld_id),
    .i_val  (bus.fld_val),
    .o_word (w_packed),
    .o_bad  (w_bad)
  );

  assign bus.fld_ready = (r_state != ST_RUN);
  assign w_acc         = bus.fld_valid & bus.fld_ready;
  assign w_stage_nxt   = w_acc ? w_packed : r_stage;
  assign w_full        = (r_cnt == CNT_MAX);
  assign w_mem_we      = (r_state != ST_RUN) & ~bus.clear & bus.commit & ~w_full;
  assign w_nxt         = (({1'b0, r_idx} + 1'b1) == r_cnt) ? '0 : r_idx + 1'b1;

  // Storage only; contents are don't-care after reset and gated by r_cnt.
  always_ff @(posedge CLK) begin
    if (w_mem_we) r_mem[r_cnt[AW-1:0]] <= w_stage_nxt;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_IDLE;
      r_stage <= '0;
      r_dout  <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (bus.stop) begin
            r_state <= ST_IDLE;
            r_dout  <= '0;
            r_idx   <= '0;
          end else begin
            r_idx  <= w_nxt;
            r_dout <= r_mem[w_nxt];
          end
        end
        default: begin
          if (bus.clear) begin
            r_state <= ST_IDLE;
            r_stage <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
          end else begin
            if (w_acc && w_bad) r_err <= 1'b1;
            if (bus.commit) begin
              // A commit on a full memory is dropped, but a same-cycle write still lands.
              if (w_full) begin
                r_err   <= 1'b1;
                r_stage <= w_stage_nxt;
                if (w_acc) r_state <= ST_LOAD;
              end else begin
                r_stage <= '0;
                r_cnt   <= r_cnt + 1'b1;
                r_state <= ST_LOAD;
              end
            end else if (bus.start && r_cnt != '0) begin
              r_state <= ST_RUN;
              r_stage <= w_stage_nxt;
              r_idx   <= '0;
              r_dout  <= r_mem[0];
            end else begin
              r_stage <= w_stage_nxt;
              if (w_acc) r_state <= ST_LOAD;
            end
          end
        end
      endcase
    end
  end

  assign bus.data_out  = r_dout;
  assign bus.running   = (r_state == ST_RUN);
  assign bus.ctx_idx   = r_idx;
  assign bus.ctx_count = r_cnt;
  assign bus.err       = r_err;
endmodule

// File: tb/tb_ctx_sequencer.sv
// Directed bench for ctx_sequencer: field packing, commit/replay ordering,
// full-memory and bad-id errors, control priorities and async reset.
module tb_ctx_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic [120:0] e;
  int   bits [4];
  logic [3:0] idxs [4];

  always #5 clk = ~clk;

  ctx_sequencer_if #(.CW(121), .AW(4)) bus ();

  ctx_sequencer #(.width(120), .DEPTH(16), .AW(4)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wrc(input logic [4:0] id, input logic [8:0] val, input logic c);
    bus.fld_valid = 1'b1;
    bus.fld_id    = id;
    bus.fld_val   = val;
    bus.commit    = c;
    tick();
    bus.fld_valid = 1'b0;
    bus.commit    = 1'b0;
  endtask

  task automatic pulse_commit();
    bus.commit = 1'b1; tick(); bus.commit = 1'b0;
  endtask
  task automatic pulse_start();
    bus.start = 1'b1; tick(); bus.start = 1'b0;
  endtask
  task automatic pulse_stop();
    bus.stop = 1'b1; tick(); bus.stop = 1'b0;
  endtask
  task automatic pulse_clear();
    bus.clear = 1'b1; tick(); bus.clear = 1'b0;
  endtask

  initial begin
    bus.fld_valid = 1'b0; bus.fld_id = '0; bus.fld_val = '0;
    bus.commit = 1'b0; bus.start = 1'b0; bus.stop = 1'b0; bus.clear = 1'b0;
    #12 rst_n = 1'b1;
    tick();
    chk("rst_data", bus.data_out, 0);
    chk("rst_count", bus.ctx_count, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_running", bus.running, 0);
    chk("rst_idx", bus.ctx_idx, 0);
    chk("rst_ready", bus.fld_ready, 1);

    // single context: op_mode, imm_val, in
    wrc(5'd18, 9'h009, 1'b0);
    wrc(5'd20, 9'h0A5, 1'b0);
    wrc(5'd0, 9'h002, 1'b0);
    chk("load_running", bus.running, 0);
    pulse_commit();
    chk("one_count", bus.ctx_count, 1);
    pulse_start();
    e = '0; e[120:113] = 8'hA5; e[111:104] = 8'h09; e[8:0] = 9'h002;
    chk("one_data", bus.data_out, e);
    chk("one_running", bus.running, 1);
    chk("one_ready", bus.fld_ready, 0);
    tick();
    chk("one_hold", bus.data_out, e);
    pulse_stop();
    chk("stop_data", bus.data_out, 0);
    chk("stop_running", bus.running, 0);
    pulse_clear();
    chk("clear_count", bus.ctx_count, 0);

    // three contexts, first write merged into its commit
    wrc(5'd19, 9'h001, 1'b1);
    wrc(5'd9, 9'h001, 1'b0);
    pulse_commit();
    wrc(5'd17, 9'h001, 1'b1);
    chk("three_count", bus.ctx_count, 3);
    bits[0] = 112; bits[1] = 56; bits[2] = 103; bits[3] = 112;
    idxs[0] = 4'd0; idxs[1] = 4'd1; idxs[2] = 4'd2; idxs[3] = 4'd0;
    pulse_start();
    for (int k = 0; k < 4; k++) begin
      if (k != 0) tick();
      e = '0; e[bits[k]] = 1'b1;
      chk($sformatf("cyc_data%0d", k), bus.data_out, e);
      chk($sformatf("cyc_idx%0d", k), bus.ctx_idx, idxs[k]);
    end
    bus.stop = 1'b1; bus.start = 1'b1; tick(); bus.stop = 1'b0; bus.start = 1'b0;
    chk("stopstart_running", bus.running, 0);
    chk("stopstart_data", bus.data_out, 0);
    chk("stopstart_idx", bus.ctx_idx, 0);
    pulse_start();
    e = '0; e[112] = 1'b1;
    chk("replay_data", bus.data_out, e);
    pulse_stop();
    pulse_clear();

    // field masking and bad id
    wrc(5'd7, 9'h1FF, 1'b0);
    wrc(5'd25, 9'h1FF, 1'b0);
    chk("badid_err", bus.err, 1);
    pulse_commit();
    pulse_start();
    e = '0; e[51:48] = 4'hF;
    chk("mask_data", bus.data_out, e);
    pulse_stop();
    pulse_clear();
    chk("clear_err", bus.err, 0);

    // fill all 16 slots, then overflow
    for (int i = 0; i < 16; i++) wrc(5'd1, 9'(i + 1), 1'b1);
    chk("full_count", bus.ctx_count, 16);
    chk("full_err0", bus.err, 0);
    wrc(5'd0, 9'h001, 1'b1);
    chk("ovf_count", bus.ctx_count, 16);
    chk("ovf_err", bus.err, 1);
    pulse_start();
    e = '0; e[17:9] = 9'd1;
    chk("full_first", bus.data_out, e);
    for (int i = 0; i < 15; i++) tick();
    e = '0; e[17:9] = 9'd16;
    chk("full_last_data", bus.data_out, e);
    chk("full_last_idx", bus.ctx_idx, 15);
    tick();
    e = '0; e[17:9] = 9'd1;
    chk("full_wrap_data", bus.data_out, e);
    chk("full_wrap_idx", bus.ctx_idx, 0);
    pulse_stop();
    pulse_clear();

    // commit beats start
    wrc(5'd0, 9'h003, 1'b1);
    bus.start = 1'b1;
    wrc(5'd0, 9'h005, 1'b1);
    bus.start = 1'b0;
    chk("cs_count", bus.ctx_count, 2);
    chk("cs_running", bus.running, 0);
    pulse_start();
    chk("cs_data0", bus.data_out, 3);
    tick();
    chk("cs_data1", bus.data_out, 5);

    // async reset between edges during RUN
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_data", bus.data_out, 0);
    chk("arst_running", bus.running, 0);
    chk("arst_count", bus.ctx_count, 0);
    #2 rst_n = 1'b1;
    tick();
    chk("arst_idx", bus.ctx_idx, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
